// File: rtl/poly_result_packer_pkg.sv
// Purpose: shared constants and FSM state type for the polynomial result packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package poly_result_packer_pkg;

    localparam int N_COEFF        = 256;
    localparam int COEFF_W        = 13;
    localparam int LANES          = 4;
    localparam int READS_PER_POLY = N_COEFF / LANES;     // 64 samples per polynomial
    localparam int WORDS_PACKED13 = 52;                  // 256 * 13 / 64
    localparam int WORDS_U16      = 64;                  // 256 * 16 / 64
    localparam int PACK_IN_W      = LANES * COEFF_W;     // 52 new bits per sample
    localparam int PACK_BUF_W     = 115;                 // 63 leftover bits + 52 new bits

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/poly_result_packer_bit_packer_52to64.sv
// Purpose: accumulates 52-bit chunks LSB-first and peels off 64-bit words.
// Latency: emit decision/word are combinational on the sample; buffer updates at the edge.
// Backpressure: none; the consumer must accept one word on any edge emit_o is high.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clr_i          clears buffer and fill count (new run)
//   push_i         append din_i at the buffer tail this edge
//   din_i          four 13-bit coefficients, lane 0 in the LSBs
//   emit_o         a 64-bit word is complete this edge
//   word_o         lowest 64 bits of the buffer after the append
module bit_packer_52to64
    import poly_result_packer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 push_i,
    input  logic [PACK_IN_W-1:0] din_i,
    output logic                 emit_o,
    output logic [63:0]          word_o
);

    logic [PACK_BUF_W-1:0] buf_q, buf_d;
    logic [6:0]            fill_q, fill_d;
    logic [PACK_BUF_W-1:0] din_ext;
    logic [PACK_BUF_W-1:0] merged;

    // Fill before a push never exceeds 63, so fill + 52 always fits in 115 bits.
    always_comb begin
        din_ext = '0;
        din_ext[PACK_IN_W-1:0] = din_i;
        merged  = buf_q | (din_ext << fill_q);
        emit_o  = push_i && (fill_q >= 7'd12);     // fill + 52 >= 64
        word_o  = merged[63:0];
        buf_d   = buf_q;
        fill_d  = fill_q;
        if (push_i) begin
            if (emit_o) begin
                buf_d  = merged >> 64;
                fill_d = fill_q - 7'd12;
            end else begin
                buf_d  = merged;
                fill_d = fill_q + 7'd52;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/poly_result_packer.sv
// Purpose: drains the multiplier 4 coefficients/cycle and writes 64-bit BRAM words (13-bit dense or 4x16).
// Latency: start to done 65 cycles; each write appears the cycle after its sample edge.
// Backpressure: none; the BRAM port must accept a write every cycle wr_en is high.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start, mode16    run request and mode (sampled together; start ignored while reading)
//   read             shift strobe to the multiplier, high for 64 cycles
//   coeff4x_in       four 16-bit coefficient lanes, valid while read is high
//   wr_en/addr/data  registered BRAM write port
//   busy, done       run in progress / sticky completion
module poly_result_packer
    import poly_result_packer_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode16,
    output logic              read,
    input  logic [63:0]       coeff4x_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              busy,
    output logic              done
);

    state_t              state_q;
    logic                mode16_q;
    logic [5:0]          rd_cnt_q;
    logic [ADDR_W-1:0]   addr_cnt_q;
    logic                read_q, wr_en_q, busy_q, done_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [63:0]         wr_data_q;

    logic                    accept_start;
    logic                    pk_push, pk_emit;
    logic [PACK_IN_W-1:0]    pk_din;
    logic [63:0]             pk_word;
    logic                    wr_d;
    logic [63:0]             wr_data_d;

    assign accept_start = start && (state_q != READ);

    // Drop lane bits [15:13]; lane 0 lands in the LSBs.
    always_comb begin
        pk_din = '0;
        for (int j = 0; j < LANES; j++) begin
            pk_din[j*COEFF_W +: COEFF_W] = coeff4x_in[16*j +: COEFF_W];
        end
    end

    assign pk_push   = (state_q == READ) && !mode16_q;
    assign wr_d      = (state_q == READ) && (mode16_q || pk_emit);
    assign wr_data_d = mode16_q ? coeff4x_in : pk_word;

    bit_packer_52to64 u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept_start),
        .push_i (pk_push),
        .din_i  (pk_din),
        .emit_o (pk_emit),
        .word_o (pk_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode16_q   <= 1'b0;
            rd_cnt_q   <= '0;
            addr_cnt_q <= '0;
            read_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    wr_en_q <= 1'b0;
                    if (accept_start) begin
                        state_q    <= READ;
                        mode16_q   <= mode16;
                        rd_cnt_q   <= '0;
                        addr_cnt_q <= '0;
                        wr_addr_q  <= '0;
                        read_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end else if (state_q == DONE) begin
                        // Final write is on the bus this cycle; completion shows one edge later.
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                READ: begin
                    rd_cnt_q <= rd_cnt_q + 6'd1;
                    wr_en_q  <= wr_d;
                    if (wr_d) begin
                        wr_data_q  <= wr_data_d;
                        wr_addr_q  <= addr_cnt_q;
                        addr_cnt_q <= addr_cnt_q + 1'b1;
                    end
                    if (rd_cnt_q == 6'(READS_PER_POLY - 1)) begin
                        state_q <= DONE;
                        read_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign read    = read_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
